// File: rtl/msi_arb_pkg.sv
// Shared types and helpers for the MSI interrupt arbiter.
// Vector numbers are 5 bits wide because the host can allocate at most 32 MSI vectors.
package msi_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam int MSI_VEC_W = 5;

  // Mask of usable vector bits; allocations above 32 vectors saturate at 32.
  function automatic logic [MSI_VEC_W-1:0] vec_mask(input logic [2:0] width);
    logic [2:0] w;
    logic [MSI_VEC_W:0] full;
    w = (width > 3'd5) ? 3'd5 : width;
    full = (6'd1 << w) - 6'd1;
    return full[MSI_VEC_W-1:0];
  endfunction

endpackage

// File: rtl/msi_rr_pick.sv
// Combinational round-robin selector: the first eligible index after last_idx wins,
// wrapping around so that last_idx itself has the lowest priority.
module msi_rr_pick
  import msi_arb_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0]   elig,
  input  logic [MSI_VEC_W-1:0] last_idx,
  output logic                 any,
  output logic [MSI_VEC_W-1:0] sel_idx
);

  always_comb begin
    int idx;
    any     = 1'b0;
    sel_idx = '0;
    idx     = 0;
    for (int off = 1; off <= NUM_SRC; off++) begin
      // last_idx < NUM_SRC, so a single subtraction is enough to wrap
      idx = int'(last_idx) + off;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!any && elig[idx]) begin
        any     = 1'b1;
        sel_idx = MSI_VEC_W'(idx);
      end
    end
  end

endmodule

// File: rtl/msi_irq_arbiter.sv
// Shares the PCIe core MSI request/grant port among NUM_SRC edge-triggered sources.
// state | meaning
// IDLE  | no request outstanding; loads the next eligible source when MSI is enabled
// REQ   | request and latched vector held until the core grants
module msi_irq_arbiter
  import msi_arb_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   irq_in,
  input  logic                 mask_we,
  input  logic [NUM_SRC-1:0]   mask_wdata,
  output logic [NUM_SRC-1:0]   mask_q,
  output logic [NUM_SRC-1:0]   pending_q,
  input  logic                 msi_enable,
  input  logic [2:0]           msi_vector_width,
  output logic                 intx_msi_request,
  input  logic                 intx_msi_grant,
  output logic [MSI_VEC_W-1:0] msi_vector_num,
  output logic                 busy,
  output logic [CNT_W-1:0]     msi_count
);

  state_t                 state_q, state_d;
  logic [NUM_SRC-1:0]     irq_prev, rise, elig, clr;
  logic [MSI_VEC_W-1:0]   last_idx, sel_idx, sel_q, vec_q;
  logic [CNT_W-1:0]       count_q;
  logic                   any, load, done;

  assign rise = irq_in & ~irq_prev;
  assign elig = pending_q & ~mask_q;

  msi_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .elig     (elig),
    .last_idx (last_idx),
    .any      (any),
    .sel_idx  (sel_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (msi_enable && any) begin
          load    = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (intx_msi_grant) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr[i] = done && (sel_q == MSI_VEC_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_prev  <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      last_idx  <= MSI_VEC_W'(NUM_SRC - 1);
      sel_q     <= '0;
      vec_q     <= '0;
      count_q   <= '0;
    end else begin
      irq_prev <= irq_in;
      // a new edge in the grant cycle must not be lost, so set overrides clear
      pending_q <= (pending_q & ~clr) | rise;
      if (mask_we) mask_q <= mask_wdata;
      if (load) begin
        sel_q <= sel_idx;
        vec_q <= sel_idx & vec_mask(msi_vector_width);
      end
      if (done) begin
        last_idx <= sel_q;
        count_q  <= count_q + 1'b1;
      end
    end
  end

  assign intx_msi_request = (state_q == REQ);
  assign busy             = (state_q == REQ);
  assign msi_vector_num   = vec_q;
  assign msi_count        = count_q;

endmodule

// File: tb/tb_msi_irq_arbiter.sv
// Directed bench for msi_irq_arbiter: a cycle-by-cycle vector table plus a few
// hand-written sequences for back-to-back grants and counter wrap.
module tb_msi_irq_arbiter;

  localparam int NS  = 32;
  localparam int CW  = 4;

  logic          clk;
  logic          rst_n;
  logic [NS-1:0] irq_in;
  logic          mask_we;
  logic [NS-1:0] mask_wdata;
  logic [NS-1:0] mask_q;
  logic [NS-1:0] pending_q;
  logic          msi_enable;
  logic [2:0]    msi_vector_width;
  logic          intx_msi_request;
  logic          intx_msi_grant;
  logic [4:0]    msi_vector_num;
  logic          busy;
  logic [CW-1:0] msi_count;

  int checks   = 0;
  int failures = 0;

  msi_irq_arbiter #(
    .NUM_SRC (NS),
    .CNT_W   (CW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .irq_in           (irq_in),
    .mask_we          (mask_we),
    .mask_wdata       (mask_wdata),
    .mask_q           (mask_q),
    .pending_q        (pending_q),
    .msi_enable       (msi_enable),
    .msi_vector_width (msi_vector_width),
    .intx_msi_request (intx_msi_request),
    .intx_msi_grant   (intx_msi_grant),
    .msi_vector_num   (msi_vector_num),
    .busy             (busy),
    .msi_count        (msi_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [NS-1:0] irq;
    logic          mwe;
    logic [NS-1:0] mwd;
    logic          en;
    logic [2:0]    w;
    logic          gnt;
    logic          req;
    logic [4:0]    vec;
    logic [NS-1:0] pend;
    logic [CW-1:0] cnt;
    logic [NS-1:0] mask;
  } vec_t;

  vec_t tbl[$];
  int   model_cnt;

  function automatic void add(logic rst, logic [NS-1:0] irq, logic mwe, logic [NS-1:0] mwd,
                              logic en, logic [2:0] w, logic gnt, logic req, logic [4:0] vec,
                              logic [NS-1:0] pend, logic [CW-1:0] cnt, logic [NS-1:0] mask);
    vec_t v;
    v.rst = rst; v.irq = irq; v.mwe = mwe; v.mwd = mwd; v.en = en; v.w = w; v.gnt = gnt;
    v.req = req; v.vec = vec; v.pend = pend; v.cnt = cnt; v.mask = mask;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic serve_one(input int src);
    logic [4:0] exp_vec;
    bit seen;
    exp_vec = 5'(src & 7);
    seen    = 1'b0;
    irq_in  = NS'(1) << src;
    step();
    irq_in  = '0;
    for (int k = 0; k < 8 && !seen; k++) begin
      step();
      if (intx_msi_request) seen = 1'b1;
    end
    chk($sformatf("serve%0d_req_seen", src), 32'(seen), 32'd1);
    chk($sformatf("serve%0d_vec", src), 32'(msi_vector_num), 32'(exp_vec));
    intx_msi_grant = 1'b1;
    step();
    intx_msi_grant = 1'b0;
    model_cnt = (model_cnt + 1) % (1 << CW);
    chk($sformatf("serve%0d_req_drop", src), 32'(intx_msi_request), 32'd0);
    chk($sformatf("serve%0d_pend", src), pending_q, 32'd0);
    chk($sformatf("serve%0d_cnt", src), 32'(msi_count), 32'(model_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nreq;
    bit  prev_req;

    // rst irq mwe mwd en w gnt | req vec pend cnt mask
    add(0, 0, 0, 0, 0, 3, 0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 3, 0,  0, 0, 0, 0, 0);
    // single event on source 5
    add(1, 'h20, 0, 0, 1, 3, 0,  0, 0, 'h20, 0, 0);
    add(1, 0, 0, 0, 1, 3, 0,  1, 5, 'h20, 0, 0);
    add(1, 0, 0, 0, 1, 3, 0,  1, 5, 'h20, 0, 0);
    add(1, 0, 0, 0, 1, 3, 0,  1, 5, 'h20, 0, 0);
    add(1, 0, 0, 0, 1, 3, 1,  0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 3, 0,  0, 0, 0, 1, 0);
    // round robin 1,2,6 then 0 before 6
    add(0, 0, 0, 0, 1, 3, 0,  0, 0, 0, 0, 0);
    add(1, 'h46, 0, 0, 1, 3, 0,  0, 0, 'h46, 0, 0);
    add(1, 'h46, 0, 0, 1, 3, 0,  1, 1, 'h46, 0, 0);
    add(1, 'h46, 0, 0, 1, 3, 1,  0, 0, 'h44, 1, 0);
    add(1, 'h46, 0, 0, 1, 3, 0,  1, 2, 'h44, 1, 0);
    add(1, 'h46, 0, 0, 1, 3, 1,  0, 0, 'h40, 2, 0);
    add(1, 'h46, 0, 0, 1, 3, 0,  1, 6, 'h40, 2, 0);
    add(1, 'h46, 0, 0, 1, 3, 1,  0, 0, 0, 3, 0);
    add(1, 0, 0, 0, 1, 3, 0,  0, 0, 0, 3, 0);
    add(1, 'h41, 0, 0, 1, 3, 0,  0, 0, 'h41, 3, 0);
    add(1, 0, 0, 0, 1, 3, 0,  1, 0, 'h41, 3, 0);
    add(1, 0, 0, 0, 1, 3, 1,  0, 0, 'h40, 4, 0);
    add(1, 0, 0, 0, 1, 3, 0,  1, 6, 'h40, 4, 0);
    add(1, 0, 0, 0, 1, 3, 1,  0, 0, 0, 5, 0);
    // vector fold: width 1, width 0, width 7 on source 31
    add(1, 'h80, 0, 0, 1, 1, 0,  0, 0, 'h80, 5, 0);
    add(1, 0, 0, 0, 1, 1, 0,  1, 1, 'h80, 5, 0);
    add(1, 0, 0, 0, 1, 1, 1,  0, 0, 0, 6, 0);
    add(1, 'h80, 0, 0, 1, 0, 0,  0, 0, 'h80, 6, 0);
    add(1, 0, 0, 0, 1, 0, 0,  1, 0, 'h80, 6, 0);
    add(1, 0, 0, 0, 1, 0, 1,  0, 0, 0, 7, 0);
    add(1, 'h8000_0000, 0, 0, 1, 7, 0,  0, 0, 'h8000_0000, 7, 0);
    add(1, 0, 0, 0, 1, 7, 0,  1, 31, 'h8000_0000, 7, 0);
    add(1, 0, 0, 0, 1, 7, 1,  0, 0, 0, 8, 0);
    // mask holds source 2 pending until unmasked
    add(1, 0, 1, 'h04, 1, 7, 0,  0, 0, 0, 8, 'h04);
    add(1, 'h04, 0, 0, 1, 7, 0,  0, 0, 'h04, 8, 'h04);
    add(1, 0, 0, 0, 1, 7, 0,  0, 0, 'h04, 8, 'h04);
    add(1, 0, 1, 0, 1, 7, 0,  0, 0, 'h04, 8, 0);
    add(1, 0, 0, 0, 1, 7, 0,  1, 2, 'h04, 8, 0);
    add(1, 0, 0, 0, 1, 3, 1,  0, 0, 0, 9, 0);
    // msi_enable gating; enable/mask/width changes in REQ do not disturb it
    add(1, 'h08, 0, 0, 0, 3, 0,  0, 0, 'h08, 9, 0);
    add(1, 0, 0, 0, 0, 3, 0,  0, 0, 'h08, 9, 0);
    add(1, 0, 0, 0, 1, 3, 0,  1, 3, 'h08, 9, 0);
    add(1, 0, 0, 0, 0, 3, 0,  1, 3, 'h08, 9, 0);
    add(1, 0, 1, 'hFFFF_FFFF, 0, 0, 0,  1, 3, 'h08, 9, 'hFFFF_FFFF);
    add(1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 10, 'hFFFF_FFFF);
    add(1, 0, 1, 0, 1, 3, 0,  0, 0, 0, 10, 0);
    // new edge on the served source in its grant cycle
    add(1, 'h10, 0, 0, 1, 3, 0,  0, 0, 'h10, 10, 0);
    add(1, 0, 0, 0, 1, 3, 0,  1, 4, 'h10, 10, 0);
    add(1, 'h10, 0, 0, 1, 3, 1,  0, 0, 'h10, 11, 0);
    add(1, 'h10, 0, 0, 1, 3, 0,  1, 4, 'h10, 11, 0);
    add(1, 'h10, 0, 0, 1, 3, 1,  0, 0, 0, 12, 0);
    // reset during REQ; sources high at release register an edge
    add(1, 'h30, 0, 0, 1, 3, 0,  0, 0, 'h20, 12, 0);
    add(1, 'h30, 0, 0, 1, 3, 0,  1, 5, 'h20, 12, 0);
    add(0, 'h30, 0, 0, 1, 3, 0,  0, 0, 0, 0, 0);
    add(1, 'h30, 0, 0, 1, 3, 0,  0, 0, 'h30, 0, 0);
    add(1, 'h30, 0, 0, 1, 3, 0,  1, 4, 'h30, 0, 0);
    add(1, 'h30, 0, 0, 1, 3, 1,  0, 0, 'h20, 1, 0);
    add(1, 'h30, 0, 0, 1, 3, 0,  1, 5, 'h20, 1, 0);
    add(1, 'h30, 0, 0, 1, 3, 1,  0, 0, 0, 2, 0);
    add(1, 'h30, 0, 0, 1, 3, 1,  0, 0, 0, 2, 0);

    foreach (tbl[i]) begin
      rst_n            = tbl[i].rst;
      irq_in           = tbl[i].irq;
      mask_we          = tbl[i].mwe;
      mask_wdata       = tbl[i].mwd;
      msi_enable       = tbl[i].en;
      msi_vector_width = tbl[i].w;
      intx_msi_grant   = tbl[i].gnt;
      step();
      chk($sformatf("row%0d_req", i), 32'(intx_msi_request), 32'(tbl[i].req));
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].req));
      chk($sformatf("row%0d_pend", i), pending_q, tbl[i].pend);
      chk($sformatf("row%0d_cnt", i), 32'(msi_count), 32'(tbl[i].cnt));
      chk($sformatf("row%0d_mask", i), mask_q, tbl[i].mask);
      if (tbl[i].req || !tbl[i].rst)
        chk($sformatf("row%0d_vec", i), 32'(msi_vector_num), 32'(tbl[i].vec));
    end
    model_cnt = 2;

    // grant held high: four sources served 0..3 with request dropping between each
    irq_in         = '0;
    intx_msi_grant = 1'b0;
    mask_we        = 1'b0;
    step();
    irq_in         = 'h0F;
    intx_msi_grant = 1'b1;
    nreq     = 0;
    prev_req = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (intx_msi_request) begin
        if (prev_req) chk("b2b_gap", 32'd1, 32'd0);
        if (nreq < 4) chk($sformatf("b2b_vec%0d", nreq), 32'(msi_vector_num), 32'(nreq));
        nreq++;
      end
      prev_req = intx_msi_request;
    end
    intx_msi_grant = 1'b0;
    irq_in         = '0;
    model_cnt      = model_cnt + 4;
    chk("b2b_nreq", 32'(nreq), 32'd4);
    chk("b2b_cnt", 32'(msi_count), 32'(model_cnt));
    chk("b2b_pend", pending_q, 32'd0);
    step();

    // ten more grants wrap the 4-bit counter back to zero
    for (int s = 0; s < 10; s++) serve_one(8 + s);
    chk("wrap_cnt", 32'(msi_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msi_irq_arbiter.md
Name: msi_irq_arbiter

Overview:
- Shares the single PCIe core MSI request/grant interface (intx_msi_request / intx_msi_grant / msi_vector_num) among NUM_SRC interrupt sources.
- Edge-detects each source into a pending bit and applies a software mask.
- Picks one unmasked pending source round-robin and maps it to an MSI vector within the allocation granted by the host (msi_vector_width).
- Sits between user interrupt sources and the 7-series PCIe core interrupt port; the mask is written by the AXI-Lite BAR register block.

Parameters:
- NUM_SRC, 8, number of interrupt sources, legal 1..32.
- CNT_W, 16, width of the issued-MSI counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- irq_in  in  NUM_SRC  per-source interrupt level, synchronous to clk; a 0→1 transition raises an event.
- mask_we  in  1  mask write strobe.
- mask_wdata  in  NUM_SRC  new mask value; 1 = source masked.
- mask_q  out  NUM_SRC  current mask.
- pending_q  out  NUM_SRC  current pending bits.
- msi_enable  in  1  MSI enable from the core config space.
- msi_vector_width  in  3  log2 of vectors allocated by the host; 6 and 7 are treated as 5.
- intx_msi_request  out  1  interrupt request to the core.
- intx_msi_grant  in  1  one-cycle grant from the core.
- msi_vector_num  out  5  vector presented with the request.
- busy  out  1  high while a request is outstanding (FSM in REQ).
- msi_count  out  CNT_W  number of grants received; wraps.

Behaviour:
- Reset values:
  - mask_q = 0, pending_q = 0, irq_prev = 0.
  - intx_msi_request = 0, msi_vector_num = 0, busy = 0, msi_count = 0.
  - last_idx = NUM_SRC-1, so source 0 has first priority.
  - FSM = IDLE.
  - A source already high when reset is released registers an edge on the first active cycle.
- Edge detection: edge[i] = irq_in[i] & ~irq_prev[i]; irq_prev <= irq_in every cycle.
- Pending bits:
  - pending[i] is set by edge[i] and cleared on a grant to source i.
  - If set and clear coincide, set wins (bit stays 1).
  - Masked sources still latch pending; unmasking later makes them eligible.
- Mask: mask_we=1 loads mask_wdata at the next edge and takes effect for arbitration on the following cycle.
- Eligibility: elig = pending & ~mask.
- Round-robin pick: search indices last_idx+1 … NUM_SRC-1, then 0 … last_idx; the first set elig bit wins.
- Vector mapping:
  - alloc = min(msi_vector_width, 5).
  - vec = sel_idx[4:0] & ((1<<alloc)-1), i.e. sources fold modulo the allocated vectors.
  - Width 0 puts every source on vector 0.
- FSM state IDLE:
  - If msi_enable=1 and elig≠0, at the clock edge:
    - latch sel_idx and msi_vector_num = vec;
    - intx_msi_request <= 1, busy <= 1;
    - go to REQ.
  - Otherwise stay in IDLE with request 0.
- FSM state REQ:
  - Hold intx_msi_request=1 and msi_vector_num stable until intx_msi_grant=1.
  - On grant:
    - request <= 0, busy <= 0;
    - clear pending[sel_idx] (subject to set-wins);
    - last_idx <= sel_idx;
    - msi_count <= msi_count+1, modulo 2^CNT_W;
    - go to IDLE.
  - Changes to msi_enable, mask or msi_vector_width while in REQ do not abort the handshake or change the latched vector.
  - intx_msi_grant while in IDLE is ignored.
- Latency:
  - An irq_in rising edge sampled at edge k sets pending at k; with the FSM idle and the source eligible, request is high after edge k+1.
  - Grant sampled at edge g drops request after g; the earliest next request is after edge g+1, so request is low for at least one cycle between requests.
- Reset mid-operation: rst_n=0 in REQ drops request at that edge, clears all state, and loses the pending bits.

Decomposition:
- Package msi_arb_pkg holds:
  - FSM state enum {IDLE, REQ};
  - constant MSI_VEC_W=5;
  - function vec_mask(width) returning the 5-bit mask with width saturated at 5.
- Sub-module msi_rr_pick: combinational round-robin selector.
  - Inputs: elig[NUM_SRC], last_idx.
  - Outputs: any, sel_idx[4:0].
  - Instanced once.

Test Plan:
- Single event, width 3, msi_enable=1: pulse irq_in[5] for one cycle → request high 2 cycles after the sampled rise, vector 5. Grant 3 cycles later → request low next cycle, pending_q=0, msi_count=1.
- Round-robin, width 3: raise irq_in[1], [2], [6] in the same cycle, grant each request after 1 cycle → vectors 1, 2, 6 in order, request low ≥1 cycle between each. Then raise [0] and [6] together → 0 is served before 6.
- Vector fold: msi_vector_width=1, event on source 7 → vector 1. With width 0 → vector 0. With width 7 and NUM_SRC=32, source 31 → vector 31.
- Mask: mask_wdata=0x04, then edge on source 2 → pending_q=0x04 and no request. Write mask 0 → request with vector 2 two cycles after the mask write.
- msi_enable=0: edge on source 3 → pending only, no request. Raise msi_enable → request with vector 3 next cycle. Drop msi_enable while in REQ → request held until grant.
- Collisions and reset:
  - New edge on the served source in the grant cycle → pending stays 1 and a second request follows.
  - rst_n low during REQ → request=0, pending_q=0, msi_count=0 after that edge.
